regfile: RTL and testbench
==========================

# regfile

Per-thread general-purpose register file for the GPU core: sixteen 8-bit registers with two registered read ports (rs, rt) and one write port (rd). Operand reads and result writeback are gated by the core pipeline state, so the file only samples or updates on the designated pipeline phases. It sits between the core's decoder/scheduler and the ALU/LSU datapath.

## Interface
- READ_STATE, 3'b011: core_state value in which rs/rt operands are latched.
- WRITE_STATE, 3'b000: core_state value in which writeback is allowed.
- clk  input  1  system clock, rising-edge.
- reset  input  1  one clock; reset is asynchronous and active-low.
- reg_write_enable  input  1  writeback request from the decoder.
- rs_addr  input  4  first source register index.
- rt_addr  input  4  second source register index.
- rd_addr  input  4  destination register index.
- data_write  input  8  writeback data.
- core_state  input  3  current core pipeline state.
- rs  output  8  registered first operand.
- rt  output  8  registered second operand.

## Operation
- Storage: 16 × 8-bit registers, indices 0–15; all addresses valid, no wrap or range check.
- Write: at rising clk edge, if reset high, reg_write_enable = 1 and core_state == WRITE_STATE, registers[rd_addr] <= data_write. Otherwise no register changes.
- Read: at rising clk edge, if reset high and core_state == READ_STATE, rs <= registers[rs_addr], rt <= registers[rt_addr]. rs_addr == rt_addr is legal; both ports return the same value.
- Outside READ_STATE, rs/rt hold their last latched values.
- reg_write_enable is ignored outside WRITE_STATE; core_state outside both states is a no-op.
- If READ_STATE == WRITE_STATE and a read and write hit the same register in one edge, the read returns the pre-write value.

## Timing
- Reset (reset = 0, asynchronous): all 16 registers = 8'h00, rs = 8'h00, rt = 8'h00, effective immediately. Writes and reads are suppressed while reset is low.
- Deassertion is synchronized by the caller; first action occurs on the first rising edge with reset high.
- Write latency: 1 edge; the value is visible to a read at any later READ_STATE edge.
- Read latency: 1 edge; rs/rt are valid after the edge on which core_state == READ_STATE.
- Reset asserted mid-operation: contents and outputs are cleared at once; any pending write is lost.

## Configuration
- REGFILE_ZERO_REG_EN defined: register 0 is hardwired to 8'h00; writes to rd_addr = 0 are discarded and reads of index 0 return 0.
- Not defined: register 0 is an ordinary read/write register.

## Structure
- Shared package gpu_pkg holds the core_state enum (IDLE=000, FETCH=001, DECODE=010, REQUEST=011, WAIT=100, EXECUTE=101, UPDATE=110, DONE=111), DATA_W=8, REG_ADDR_W=4 and NUM_REGS=16. READ_STATE and WRITE_STATE defaults map to REQUEST and IDLE respectively.
- Single flat module; no sub-module is required.

## Test plan
- Reset: hold reset = 0 for 2 cycles with random inputs -> rs = rt = 0; a later read of every register returns 0.
- Write/read: in WRITE_STATE write r2 = 127 and then r3 = 63; set READ_STATE with rs_addr = 2, rt_addr = 3 -> after 1 edge rs = 127, rt = 63.
- Gating: with reg_write_enable = 1 and core_state = 101, write r5 = 8'hAA -> a read of r5 returns 0. With reg_write_enable = 0 in WRITE_STATE -> no change.
- Hold: after reading r2 = 127, change rs_addr to 3 while in core_state = 101 -> rs stays 127.
- Async reset mid-run: after loading r2 and r3, pulse reset low between clock edges -> rs and rt drop to 0 immediately, and a later read of r2 returns 0.
- Zero register (REGFILE_ZERO_REG_EN defined): write r0 = 8'h55 -> a read of r0 returns 0. Without the macro the read returns 8'h55.

Source files
------------

// File: rtl/gpu_pkg.sv
// Shared GPU core definitions: pipeline state encoding and datapath widths.
package gpu_pkg;

    localparam int DATA_W     = 8;
    localparam int REG_ADDR_W = 4;
    localparam int NUM_REGS   = 16;

    typedef enum logic [2:0] {
        IDLE    = 3'b000,
        FETCH   = 3'b001,
        DECODE  = 3'b010,
        REQUEST = 3'b011,
        WAIT    = 3'b100,
        EXECUTE = 3'b101,
        UPDATE  = 3'b110,
        DONE    = 3'b111
    } core_state_t;

endpackage

// File: rtl/regfile.sv
// Per-thread 16x8 register file with two registered read ports and one write port,
// gated by core pipeline state. Optional macro REGFILE_ZERO_REG_EN hardwires r0 to zero.
module regfile
    import gpu_pkg::*;
#(
    parameter core_state_t READ_STATE  = REQUEST,
    parameter core_state_t WRITE_STATE = IDLE
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  reg_write_enable,
    input  logic [REG_ADDR_W-1:0] rs_addr,
    input  logic [REG_ADDR_W-1:0] rt_addr,
    input  logic [REG_ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0]     data_write,
    input  logic [2:0]            core_state,
    output logic [DATA_W-1:0]     rs,
    output logic [DATA_W-1:0]     rt
);

    logic [DATA_W-1:0] regs_r [NUM_REGS];
    logic              write_en_s;
    logic              read_en_s;
    logic [DATA_W-1:0] rs_data_s;
    logic [DATA_W-1:0] rt_data_s;

    // Decode pipeline-phase gating and select operand data.
    always_comb begin
        write_en_s = 1'b0;
        read_en_s  = 1'b0;
        rs_data_s  = regs_r[rs_addr];
        rt_data_s  = regs_r[rt_addr];
        if (core_state == WRITE_STATE) begin
            write_en_s = reg_write_enable;
        end else begin
            write_en_s = 1'b0;
        end
        if (core_state == READ_STATE) begin
            read_en_s = 1'b1;
        end else begin
            read_en_s = 1'b0;
        end
`ifdef REGFILE_ZERO_REG_EN
        if (rd_addr == {REG_ADDR_W{1'b0}}) begin
            write_en_s = 1'b0;
        end else begin
            write_en_s = write_en_s;
        end
        if (rs_addr == {REG_ADDR_W{1'b0}}) begin
            rs_data_s = {DATA_W{1'b0}};
        end else begin
            rs_data_s = regs_r[rs_addr];
        end
        if (rt_addr == {REG_ADDR_W{1'b0}}) begin
            rt_data_s = {DATA_W{1'b0}};
        end else begin
            rt_data_s = regs_r[rt_addr];
        end
`endif
    end

    // Register storage: cleared on reset, written on the writeback phase.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_r[i] <= {DATA_W{1'b0}};
            end
        end else if (write_en_s) begin
            regs_r[rd_addr] <= data_write;
        end
    end

    // Operand latches; nonblocking semantics give pre-write data on a same-edge hit.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rs <= {DATA_W{1'b0}};
            rt <= {DATA_W{1'b0}};
        end else if (read_en_s) begin
            rs <= rs_data_s;
            rt <= rt_data_s;
        end
    end

endmodule

// File: tb/tb_regfile.sv
// Self-checking bench for regfile: directed vector table, reset sequences and
// randomized traffic against an array-based reference model.
module tb_regfile;

    logic       clk;
    logic       reset;
    logic       reg_write_enable;
    logic [3:0] rs_addr;
    logic [3:0] rt_addr;
    logic [3:0] rd_addr;
    logic [7:0] data_write;
    logic [2:0] core_state;
    logic [7:0] rs;
    logic [7:0] rt;

    int n_cmp;
    int n_bad;

    regfile dut (
        .clk              (clk),
        .reset            (reset),
        .reg_write_enable (reg_write_enable),
        .rs_addr          (rs_addr),
        .rt_addr          (rt_addr),
        .rd_addr          (rd_addr),
        .data_write       (data_write),
        .core_state       (core_state),
        .rs               (rs),
        .rt               (rt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       we;
        logic [2:0] st;
        logic [3:0] ra;
        logic [3:0] rb;
        logic [3:0] rd;
        logic [7:0] d;
        logic [7:0] exp_rs;
        logic [7:0] exp_rt;
    } vec_t;

    vec_t vecs [11];
    logic [7:0] model_mem [16];
    logic [7:0] model_rs;
    logic [7:0] model_rt;
    logic [7:0] r0_exp;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %02h expected %02h", name, act, exp);
        end
    endtask

    task automatic step(input logic we, input logic [2:0] st, input logic [3:0] ra,
                        input logic [3:0] rb, input logic [3:0] rd, input logic [7:0] d);
        reg_write_enable = we;
        core_state       = st;
        rs_addr          = ra;
        rt_addr          = rb;
        rd_addr          = rd;
        data_write       = d;
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
`ifdef REGFILE_ZERO_REG_EN
        r0_exp = 8'h00;
`else
        r0_exp = 8'h55;
`endif
        //          we    st      ra     rb     rd     d      rs     rt
        vecs[0]  = '{1'b1, 3'd0, 4'd0, 4'd0, 4'd2, 8'd127, 8'h00, 8'h00};
        vecs[1]  = '{1'b1, 3'd0, 4'd0, 4'd0, 4'd3, 8'd63,  8'h00, 8'h00};
        vecs[2]  = '{1'b0, 3'd3, 4'd2, 4'd3, 4'd0, 8'h00,  8'd127, 8'd63};
        vecs[3]  = '{1'b1, 3'd5, 4'd3, 4'd3, 4'd5, 8'hAA,  8'd127, 8'd63};
        vecs[4]  = '{1'b0, 3'd3, 4'd5, 4'd5, 4'd0, 8'h00,  8'h00, 8'h00};
        vecs[5]  = '{1'b0, 3'd0, 4'd2, 4'd2, 4'd2, 8'h11,  8'h00, 8'h00};
        vecs[6]  = '{1'b0, 3'd3, 4'd2, 4'd2, 4'd0, 8'h00,  8'd127, 8'd127};
        vecs[7]  = '{1'b1, 3'd0, 4'd0, 4'd0, 4'd0, 8'h55,  8'd127, 8'd127};
        vecs[8]  = '{1'b0, 3'd3, 4'd0, 4'd3, 4'd0, 8'h00,  r0_exp, 8'd63};
        vecs[9]  = '{1'b1, 3'd2, 4'd3, 4'd3, 4'd3, 8'h00,  r0_exp, 8'd63};
        vecs[10] = '{1'b0, 3'd3, 4'd3, 4'd3, 4'd0, 8'h00,  8'd63, 8'd63};

        // Reset held for two cycles with random inputs.
        reset = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step(1'($urandom), 3'($urandom), 4'($urandom), 4'($urandom), 4'($urandom), 8'($urandom));
        end
        check("reset_rs", rs, 8'h00);
        check("reset_rt", rt, 8'h00);
        reset = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 3'd3, 4'(2 * i), 4'(2 * i + 1), 4'd0, 8'h00);
            check("reset_read_rs", rs, 8'h00);
            check("reset_read_rt", rt, 8'h00);
        end

        // Directed vector table.
        for (int i = 0; i < 11; i++) begin
            step(vecs[i].we, vecs[i].st, vecs[i].ra, vecs[i].rb, vecs[i].rd, vecs[i].d);
            check($sformatf("vec%0d_rs", i), rs, vecs[i].exp_rs);
            check($sformatf("vec%0d_rt", i), rt, vecs[i].exp_rt);
        end

        // Async reset between edges after r2/r3 are loaded and latched.
        step(1'b0, 3'd3, 4'd2, 4'd3, 4'd0, 8'h00);
        check("pre_async_rs", rs, 8'd127);
        #2;
        reset = 1'b0;
        #1;
        check("async_rs", rs, 8'h00);
        check("async_rt", rt, 8'h00);
        #1;
        reset = 1'b1;
        step(1'b0, 3'd3, 4'd2, 4'd3, 4'd0, 8'h00);
        check("post_async_r2", rs, 8'h00);
        check("post_async_r3", rt, 8'h00);

        // Randomized traffic against the reference model.
        for (int i = 0; i < 16; i++) model_mem[i] = 8'h00;
        model_rs = 8'h00;
        model_rt = 8'h00;
        for (int n = 0; n < 600; n++) begin
            logic       we;
            logic [2:0] st;
            logic [3:0] ra;
            logic [3:0] rb;
            logic [3:0] rd;
            logic [7:0] d;
            int         pick;
            we   = 1'($urandom);
            pick = int'($urandom_range(0, 3));
            st   = (pick == 0) ? 3'd0 : (pick == 1) ? 3'd3 : 3'($urandom);
            ra   = 4'($urandom);
            rb   = 4'($urandom);
            rd   = 4'($urandom);
            d    = 8'($urandom);
            if (st == 3'd3) begin
                model_rs = model_mem[ra];
                model_rt = model_mem[rb];
`ifdef REGFILE_ZERO_REG_EN
                if (ra == 4'd0) model_rs = 8'h00;
                if (rb == 4'd0) model_rt = 8'h00;
`endif
            end
            if (st == 3'd0 && we) begin
`ifdef REGFILE_ZERO_REG_EN
                if (rd != 4'd0) model_mem[rd] = d;
`else
                model_mem[rd] = d;
`endif
            end
            step(we, st, ra, rb, rd, d);
            check("rand_rs", rs, model_rs);
            check("rand_rt", rt, model_rt);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
